// File: rtl/proc_run_ctrl_pkg.sv
// proc_run_pkg: shared types and constants for the processor run controller.
//   run_state_e : controller states IDLE / RUN / DONE
//   ECALL_INST  : encoding of ECALL, the instruction that ends a run
//   REG_ADDR_W  : register-file address width (x0..x31)
package proc_run_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } run_state_e;

   localparam logic [31:0] ECALL_INST = 32'h0000_0073;
   localparam int          REG_ADDR_W = 5;

endpackage

// File: rtl/proc_run_ctrl_if.sv
// proc_run_ctrl_if: program-load handshake into the run controller.
//   load_valid : program word offered (master -> slave)
//   load_ready : controller accepts the word (slave -> master)
//   load_addr  : imem word address
//   load_data  : instruction word
// A word transfers in any cycle where load_valid && load_ready.
interface proc_run_ctrl_if #(
   parameter int ADDR_W = 8,
   parameter int XLEN   = 32
);
   logic              load_valid;
   logic              load_ready;
   logic [ADDR_W-1:0] load_addr;
   logic [XLEN-1:0]   load_data;

   modport master (output load_valid, output load_addr, output load_data, input  load_ready);
   modport slave  (input  load_valid, input  load_addr, input  load_data, output load_ready);
endinterface

// File: rtl/proc_run_ctrl_halt_detect.sv
// proc_halt_detect: decides when the observed core has halted.
//   clk, rst : clock / asynchronous active-high reset (used only by stuck logic)
//   run      : controller is in RUN
//   pc_in    : core program counter
//   inst_in  : currently fetched instruction
//   halt_o   : halt seen this cycle (ECALL fetched, or PC stuck)
// Optional feature macro PROC_RUN_STUCK_DETECT_EN: when defined, a PC that stays
// unchanged for STUCK_CYCLES consecutive cycles also counts as a halt (catches
// a "j ." self-loop). When undefined, only ECALL halts and no stuck state exists.
module proc_halt_detect
   import proc_run_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int STUCK_CYCLES = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] inst_in,
   output logic            halt_o
);

   logic ecall_hit;
   assign ecall_hit = (inst_in == XLEN'(ECALL_INST));

`ifdef PROC_RUN_STUCK_DETECT_EN
   localparam int SC_W = $clog2(STUCK_CYCLES + 1);

   logic [XLEN-1:0] prev_pc;
   logic            prev_vld;
   logic [SC_W-1:0] stuck_cnt;
   logic            pc_same;
   logic            stuck_hit;

   // prev_vld is the invalid-flag: it is clear on the first RUN cycle, so
   // that cycle can never count as a repeat of a PC from a previous run.
   assign pc_same   = prev_vld && (pc_in == prev_pc);
   // Current cycle is the STUCK_CYCLES-th consecutive repeat.
   assign stuck_hit = pc_same && (stuck_cnt == SC_W'(STUCK_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_pc   <= '0;
         prev_vld  <= 1'b0;
         stuck_cnt <= '0;
      end else if (!run) begin
         prev_vld  <= 1'b0;
         stuck_cnt <= '0;
      end else begin
         prev_pc  <= pc_in;
         prev_vld <= 1'b1;
         if (!pc_same)
            stuck_cnt <= '0;
         else if (stuck_cnt != {SC_W{1'b1}})
            stuck_cnt <= stuck_cnt + SC_W'(1);
      end
   end

   assign halt_o = run && (ecall_hit || stuck_hit);
`else
   logic unused_stuck_inputs;
   assign unused_stuck_inputs = ^{clk, rst, pc_in, 32'(STUCK_CYCLES)};

   assign halt_o = run && ecall_hit;
`endif

endmodule

// File: rtl/proc_run_ctrl.sv
// proc_run_ctrl: run controller for the single-cycle RISC-V processor.
// Streams a program into imem, releases the core from reset, counts cycles,
// stops on halt or timeout and checks register CHECK_REG against `expected`.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   ld            : program-load handshake (proc_run_ctrl_if.slave)
//   start         : single-cycle pulse, begins a run from IDLE or DONE
//   expected      : expected value of CHECK_REG at halt
//   core_rst      : reset to the processor (low only while running)
//   imem_we/waddr/wdata : imem write port, combinational from the load handshake
//   pc_in, inst_in: observed PC and fetched instruction
//   rf_raddr/rf_rdata   : register-file debug read port (address fixed to CHECK_REG)
//   busy, done, pass, timeout, cycle_count : run status
// Optional feature macro PROC_RUN_STUCK_DETECT_EN enables stuck-PC halt
// detection inside proc_halt_detect.
module proc_run_ctrl
   import proc_run_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int IMEM_DEPTH   = 256,
   parameter int CNT_W        = 32,
   parameter int MAX_CYCLES   = 1000,
   parameter int CHECK_REG    = 10,
   parameter int STUCK_CYCLES = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   proc_run_ctrl_if.slave                ld,
   input  logic                          start,
   input  logic [XLEN-1:0]               expected,
   output logic                          core_rst,
   output logic                          imem_we,
   output logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
   output logic [XLEN-1:0]               imem_wdata,
   input  logic [XLEN-1:0]               pc_in,
   input  logic [XLEN-1:0]               inst_in,
   output logic [REG_ADDR_W-1:0]         rf_raddr,
   input  logic [XLEN-1:0]               rf_rdata,
   output logic                          busy,
   output logic                          done,
   output logic                          pass,
   output logic                          timeout,
   output logic [CNT_W-1:0]              cycle_count
);

   if (MAX_CYCLES < 1) begin : g_max_low
      $error("MAX_CYCLES must be at least 1");
   end
   if (CNT_W < 63) begin : g_cnt_chk
      if (longint'(MAX_CYCLES) >= (longint'(1) << CNT_W)) begin : g_max_high
         $error("MAX_CYCLES must be below 2**CNT_W");
      end
   end

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   run_state_e state_q, state_d;
   logic       load_ready_q;
   logic       run;
   logic       halt;
   logic       budget_hit;
   logic       start_run;

   assign run        = (state_q == RUN);
   assign budget_hit = (cycle_count == CNT_W'(MAX_CYCLES - 1));
   assign start_run  = (state_q != RUN) && start;

   proc_halt_detect #(
      .XLEN         (XLEN),
      .STUCK_CYCLES (STUCK_CYCLES)
   ) u_halt (
      .clk     (clk),
      .rst     (rst),
      .run     (run),
      .pc_in   (pc_in),
      .inst_in (inst_in),
      .halt_o  (halt)
   );

   // Loads pass straight through to imem with zero latency.
   assign ld.load_ready = load_ready_q;
   assign imem_we       = ld.load_valid && load_ready_q;
   assign imem_waddr    = ld.load_addr;
   assign imem_wdata    = ld.load_data;
   assign rf_raddr      = REG_ADDR_W'(CHECK_REG);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: if (start) state_d = RUN;
         RUN:        if (halt || budget_hit) state_d = DONE;
         default:    state_d = IDLE;
      endcase
   end

   // Status registers follow the next state so they line up with state_q.
   // cycle_count advances only on cycles that stay in RUN, so at DONE it
   // holds the index of the final run cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         core_rst     <= 1'b1;
         load_ready_q <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         pass         <= 1'b0;
         timeout      <= 1'b0;
         cycle_count  <= '0;
      end else begin
         core_rst     <= (state_d != RUN);
         load_ready_q <= (state_d != RUN);
         busy         <= (state_d == RUN);
         if (start_run) begin
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
         end else if (run) begin
            if (halt) begin
               done    <= 1'b1;
               pass    <= (rf_rdata == expected);
               timeout <= 1'b0;
            end else if (budget_hit) begin
               done    <= 1'b1;
               pass    <= 1'b0;
               timeout <= 1'b1;
            end else begin
               cycle_count <= sat_inc(cycle_count);
            end
         end
      end
   end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Testbench for proc_run_ctrl: a stub core fetches from the bench's program
// image, a scoreboard checks imem writes and run results against a
// reference model evaluated over the program image.
module tb_proc_run_ctrl;
   import proc_run_pkg::*;

   localparam int XLEN = 32, IMEM_DEPTH = 256, AW = 8, CNT_W = 32;
   localparam int MAXC = 20, CHECK_REG = 10, STUCK = 4;
   localparam logic [31:0] I_ADD   = 32'h00b5_0533;
   localparam logic [31:0] I_ADDI  = 32'h0015_0513;
   localparam logic [31:0] I_ECALL = 32'h0000_0073;
   localparam logic [31:0] I_JSELF = 32'h0000_006f;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   proc_run_ctrl_if #(.ADDR_W(AW), .XLEN(XLEN)) ld_if();

   logic             start = 1'b0;
   logic [XLEN-1:0]  expected = '0;
   logic             core_rst, imem_we, busy, done, pass, timeout;
   logic [AW-1:0]    imem_waddr;
   logic [XLEN-1:0]  imem_wdata, pc_in, inst_in, rf_rdata;
   logic [4:0]       rf_raddr;
   logic [CNT_W-1:0] cycle_count;

   proc_run_ctrl #(
      .XLEN(XLEN), .IMEM_DEPTH(IMEM_DEPTH), .CNT_W(CNT_W),
      .MAX_CYCLES(MAXC), .CHECK_REG(CHECK_REG), .STUCK_CYCLES(STUCK)
   ) dut (
      .clk(clk), .rst(rst), .ld(ld_if), .start(start), .expected(expected),
      .core_rst(core_rst), .imem_we(imem_we), .imem_waddr(imem_waddr),
      .imem_wdata(imem_wdata), .pc_in(pc_in), .inst_in(inst_in),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .busy(busy), .done(done),
      .pass(pass), .timeout(timeout), .cycle_count(cycle_count)
   );

   // Program image and stub core: PC advances by 4 per cycle out of reset,
   // and holds on a "j ." instruction.
   logic [31:0] mem [IMEM_DEPTH];
   logic [31:0] pc = '0;
   logic [31:0] rfv = '0;
   assign pc_in    = pc;
   assign inst_in  = mem[pc[AW+1:2]];
   assign rf_rdata = rfv;
   always @(posedge clk) begin
      if (core_rst)               pc <= '0;
      else if (inst_in != I_JSELF) pc <= pc + 32'd4;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct { logic [AW-1:0] a; logic [31:0] d; } wr_t;
   typedef struct { logic ps; logic to; logic [CNT_W-1:0] cnt; } res_t;
   wr_t  wq[$];
   res_t rq[$];

   // Run k fetches word k until a "j ." freezes the PC. The run ends at the
   // first ECALL, (with stuck detection) STUCK cycles after a "j .", or at
   // cycle MAXC-1 by timeout.
   function automatic res_t predict(input logic [31:0] rv, input logic [31:0] ex);
      res_t r;
      r.ps = 1'b0; r.to = 1'b1; r.cnt = CNT_W'(MAXC - 1);
      for (int k = 0; k < MAXC; k++) begin
         if (mem[k] == I_ECALL) begin
            r.ps = (rv == ex); r.to = 1'b0; r.cnt = CNT_W'(k);
            return r;
         end
         if (mem[k] == I_JSELF) begin
`ifdef PROC_RUN_STUCK_DETECT_EN
            if (k + STUCK <= MAXC - 1) begin
               r.ps = (rv == ex); r.to = 1'b0; r.cnt = CNT_W'(k + STUCK);
            end
`endif
            return r;
         end
      end
      return r;
   endfunction

   // Monitor: consumes imem writes and completed runs.
   logic done_prev = 1'b0;
   always @(negedge clk) begin
      wr_t  w;
      res_t r;
      if (imem_we) begin
         if (wq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_imem_we: got addr %0h data %0h expected no write", imem_waddr, imem_wdata);
         end else begin
            w = wq.pop_front();
            check("imem_waddr", 64'(imem_waddr), 64'(w.a));
            check("imem_wdata", 64'(imem_wdata), 64'(w.d));
         end
      end
      if (done && !done_prev) begin
         if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got done=1 expected no run pending");
         end else begin
            r = rq.pop_front();
            check("pass",        64'(pass),        64'(r.ps));
            check("timeout",     64'(timeout),     64'(r.to));
            check("cycle_count", 64'(cycle_count), 64'(r.cnt));
            check("core_rst_done", 64'(core_rst),  64'd1);
            check("busy_done",   64'(busy),        64'd0);
         end
      end
      done_prev = done;
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic load_word(input logic [AW-1:0] a, input logic [31:0] d);
      wr_t w;
      w.a = a; w.d = d;
      ld_if.load_valid = 1'b1; ld_if.load_addr = a; ld_if.load_data = d;
      wq.push_back(w);
      mem[a] = d;
      tick();
      ld_if.load_valid = 1'b0;
   endtask

   task automatic run_prog(input logic [31:0] rv, input logic [31:0] ex);
      int n;
      rfv = rv; expected = ex;
      rq.push_back(predict(rv, ex));
      start = 1'b1;
      tick();
      start = 1'b0;
      check("core_rst_run", 64'(core_rst), 64'd0);
      check("busy_run",     64'(busy),     64'd1);
      check("count_start",  64'(cycle_count), 64'd0);
      check("load_ready_run", 64'(ld_if.load_ready), 64'd0);
      n = 0;
      while (!done && n < MAXC + 5) begin
         // A start pulse and a load offered mid-run must both be ignored.
         if (n == 2) begin
            start = 1'b1;
            ld_if.load_valid = 1'b1; ld_if.load_addr = '0; ld_if.load_data = 32'hdead_beef;
         end
         tick();
         start = 1'b0;
         ld_if.load_valid = 1'b0;
         n++;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL run_wait: got done=0 after %0d cycles expected done=1", n);
      end
      tick();
      check("load_ready_done", 64'(ld_if.load_ready), 64'd1);
   endtask

   initial begin
      logic [31:0] rv, ex;
      ld_if.load_valid = 1'b0; ld_if.load_addr = '0; ld_if.load_data = '0;
      for (int i = 0; i < IMEM_DEPTH; i++) mem[i] = I_ADDI;

      repeat (3) @(posedge clk);
      #1;
      check("rst_core_rst",   64'(core_rst),          64'd1);
      check("rst_load_ready", 64'(ld_if.load_ready),  64'd0);
      check("rst_imem_we",    64'(imem_we),           64'd0);
      check("rst_busy",       64'(busy),              64'd0);
      check("rst_done",       64'(done),              64'd0);
      check("rst_pass",       64'(pass),              64'd0);
      check("rst_timeout",    64'(timeout),           64'd0);
      check("rst_count",      64'(cycle_count),       64'd0);
      check("rf_raddr",       64'(rf_raddr),          64'(CHECK_REG));
      rst = 1'b0;
      tick(); tick();
      check("idle_load_ready", 64'(ld_if.load_ready), 64'd1);

      // add / addi / ecall, matching and mismatching expected value
      load_word(8'd0, I_ADD);
      load_word(8'd1, I_ADDI);
      load_word(8'd2, I_ECALL);
      run_prog(32'h0000_1234, 32'h0000_1234);
      run_prog(32'h0000_1234, 32'h0000_1235);

      // no ECALL in budget: timeout at MAXC-1
      load_word(8'd2, I_ADDI);
      run_prog(32'h5, 32'h5);

      // ECALL exactly on the last budgeted cycle: halt wins
      load_word(8'(MAXC - 1), I_ECALL);
      run_prog(32'h77, 32'h77);
      load_word(8'(MAXC - 1), I_ADDI);

      // self-loop: stuck halt with the feature, timeout without
      load_word(8'd5, I_JSELF);
      run_prog(32'h9, 32'h9);
      load_word(8'd5, I_ADDI);

      // asynchronous reset in the middle of a run
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      ld_if.load_valid = 1'b1; ld_if.load_addr = 8'd7; ld_if.load_data = 32'h1;
      #2 rst = 1'b1;
      #1;
      check("mid_rst_core_rst", 64'(core_rst),         64'd1);
      check("mid_rst_busy",     64'(busy),             64'd0);
      check("mid_rst_done",     64'(done),             64'd0);
      check("mid_rst_count",    64'(cycle_count),      64'd0);
      check("mid_rst_ready",    64'(ld_if.load_ready), 64'd0);
      check("mid_rst_imem_we",  64'(imem_we),          64'd0);
      ld_if.load_valid = 1'b0;
      tick();
      rst = 1'b0;
      tick(); tick();
      load_word(8'd3, I_ECALL);
      run_prog(32'habcd, 32'habcd);
      load_word(8'd3, I_ADDI);

      // randomized programs
      for (int it = 0; it < 10; it++) begin
         for (int k = 0; k < MAXC; k++) begin
            if ($urandom_range(0, 9) == 0) load_word(8'(k), I_ECALL);
            else if ($urandom_range(0, 1) == 1) load_word(8'(k), I_ADD);
            else load_word(8'(k), I_ADDI);
         end
         rv = $urandom;
         ex = ($urandom_range(0, 1) == 1) ? rv : rv ^ (32'd1 << $urandom_range(0, 31));
         run_prog(rv, ex);
      end

      check("wq_drained", 64'(wq.size()), 64'd0);
      check("rq_drained", 64'(rq.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/proc_run_ctrl.md
Name: proc_run_ctrl

Overview:
Synthesisable run controller for the single-cycle RISC-V processor. It replaces open-loop bench sequencing with a parametrised harness.
- Streams a program into instruction memory over a valid/ready handshake.
- Releases the core from reset and counts cycles.
- Detects halt (ECALL) or timeout, then checks one architectural register against an expected value.
- Sits beside `processor`, driving its reset and imem write port and observing PC, instruction and one register-file read port.

Parameters:
- XLEN, 32, datapath width of PC, instruction and register data.
- IMEM_DEPTH, 256, instruction memory depth in words.
- CNT_W, 32, cycle counter width.
- MAX_CYCLES, 1000, run-cycle budget before timeout.
- CHECK_REG, 10, register index compared at halt (x10/a0).
- STUCK_CYCLES, 4, consecutive unchanged-PC cycles that count as a halt (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- load_valid  in  1  program word offered
- load_ready  out  1  controller accepts program word
- load_addr  in  $clog2(IMEM_DEPTH)  word address
- load_data  in  XLEN  instruction word
- start  in  1  single-cycle pulse to begin run
- expected  in  XLEN  expected value of CHECK_REG
- core_rst  out  1  reset to processor
- imem_we  out  1  imem write enable
- imem_waddr  out  $clog2(IMEM_DEPTH)  imem write address
- imem_wdata  out  XLEN  imem write data
- pc_in  in  XLEN  processor pc_out
- inst_in  in  XLEN  current fetched instruction
- rf_raddr  out  5  register-file debug read address, constant CHECK_REG
- rf_rdata  in  XLEN  combinational read data
- busy  out  1  run in progress
- done  out  1  run finished (sticky until next start)
- pass  out  1  rf_rdata == expected at halt
- timeout  out  1  budget exhausted
- cycle_count  out  CNT_W  cycles spent in RUN

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: state=IDLE, core_rst=1, load_ready=0, imem_we=0, busy=0, done=0, pass=0, timeout=0, cycle_count=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - load_ready=1; core_rst=1.
  - On load_valid&&load_ready, the same cycle drives imem_we=1 with imem_waddr=load_addr and imem_wdata=load_data (combinational pass-through, zero latency).
  - start -> RUN next edge; cycle_count cleared to 0; done/pass/timeout cleared.
  - start coincident with load_valid: the write completes and the transition still occurs.
- RUN:
  - core_rst=0; busy=1; load_ready=0; load_valid ignored.
  - cycle_count increments every cycle, saturating at all-ones.
- Halt: in RUN, when inst_in==32'h0000_0073 (ECALL):
  - Sample pass=(rf_rdata==expected) that same cycle.
  - Go to DONE; done=1 next edge.
- Timeout: in RUN, when cycle_count==MAX_CYCLES-1 and no halt that cycle:
  - Go to DONE with timeout=1, pass=0.
  - Halt and timeout in the same cycle: halt wins, timeout=0.
- DONE:
  - core_rst=1 (core frozen); busy=0; done, pass, timeout and cycle_count hold.
  - load_ready=1, so a new program may be loaded.
  - start -> RUN (re-run without reset).
- start in RUN is ignored.
- rst mid-run: all outputs return to reset values immediately; imem contents are untouched.
- Width rules: cycle_count is unsigned CNT_W. MAX_CYCLES must be < 2**CNT_W (elaboration check).

Optional Feature:
PROC_RUN_STUCK_DETECT_EN
- Defined:
  - A stuck counter increments while pc_in equals the previous cycle's pc_in in RUN, and clears on any change.
  - Reaching STUCK_CYCLES is treated as a halt (catches `j .`), with the same pass sampling as ECALL.
  - Entering RUN loads the previous-PC register with an invalid-flag so the first cycle never matches.
- Undefined: only ECALL and timeout end a run; no stuck logic is synthesised.

Decomposition:
- Package proc_run_pkg contains:
  - the run_state_e enum (IDLE, RUN, DONE);
  - the constant ECALL_INST=32'h0000_0073;
  - the constant REG_ADDR_W=5.
- One sub-module, proc_halt_detect:
  - combinational ECALL compare;
  - under the macro, the registered stuck-PC counter;
  - outputs halt_o.

Test Plan:
- Load 3 words (add/addi/ecall) at addresses 0-2, then start. Result: imem_we seen 3 times with matching addr/data; core_rst falls one edge after start; done=1 on ECALL; pass=1 with x10 matching expected.
- Same program with expected mismatched: done=1, pass=0, timeout=0.
- Program without ECALL, MAX_CYCLES=20: done=1, timeout=1, pass=0, cycle_count=19, core_rst=1.
- ECALL fetched exactly on cycle MAX_CYCLES-1: halt wins, timeout=0.
- Assert rst at cycle 5 of RUN: outputs return to reset values asynchronously; a new start runs from cycle_count=0.
- With PROC_RUN_STUCK_DETECT_EN, program ending in `j .` (0x0000006f), STUCK_CYCLES=4: done=1 four cycles after PC freezes; without the macro, the same program times out.
